data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus CPU datapath: 16 general registers (R0–R15), PC, IR, Y, 64-bit Z (Zhigh/Zlow), HI, LO, MAR and MDR share one 32-bit bus.
- The ALU combines Y (operand A) with the bus (operand B).
- All register transfers are steered by one-hot control strobes from an external control unit or testbench.
- Memory is modelled by the Mdatain input, which is latched through MDR under Read.

Parameters:
- WIDTH, 32, bus and register width; Z is 2*WIDTH.

Ports:
- Clock  in  1  system clock, rising-edge active
- clear  in  1  asynchronous active-high reset
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout  in  1 each  bus drive selects
- R0out..R15out  in  1 each  register bus drive selects
- MARin, PCin, MDRin, IRin, Yin  in  1 each  register load enables
- IncPC  in  1  ALU computes B+1 instead of operation
- Read  in  1  MDR input mux selects Mdatain (else bus)
- ADD  in  1  forces ALU add (same as operation=1)
- R0in..R15in  in  1 each  register load enables
- Zin_high  in  1  load Zhigh (and HI) from ALU result[63:32]
- Zin_low  in  1  load Zlow (and LO) from ALU result[31:0]
- Mdatain  in  32  memory read data
- operation  in  4  ALU opcode

Behaviour:
- Clock and reset: single clock Clock; reset clear is asynchronous, active-high. While clear=1, every register (R0–R15, PC, IR, Y, Zhigh, Zlow, HI, LO, MAR, MDR) is 0 immediately, independent of Clock.
- Register loads:
  - Every register loads on the rising Clock edge when its enable is 1; otherwise it holds.
  - R0 is an ordinary register.
  - MDR loads (Read ? Mdatain : bus) when MDRin=1.
  - MAR, PC, IR, Y and R0–R15 load from the bus.
- Bus:
  - Combinational multiplexer driven by the out strobes.
  - Fixed priority when several strobes are high: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, In_Port, C.
  - No strobe high -> bus = 0.
  - In_Port drives 0 (no input port in this block).
  - C drives IR[18:0] sign-extended to 32 bits.
- ALU (combinational, 64-bit result; A=Y, B=bus):
  - Priority: IncPC=1 -> B+1; else ADD=1 -> A+B; else decode operation.
  - operation 0: result 0.
  - 1: A+B.
  - 2: A−B.
  - 3: A&B.
  - 4: A|B.
  - 5: A>>B[4:0] logical.
  - 6: A<<B[4:0].
  - 7: rotate right A by B[4:0].
  - 8: rotate left A by B[4:0].
  - 9: signed A*B, full 64-bit.
  - 10: signed divide; result[31:0]=quotient, result[63:32]=remainder. If B=0: quotient=0, remainder=A.
  - 11: −B.
  - 12: ~B.
  - 13–15: result 0.
  - Ops 1–8 and 11–12 are 32-bit, wrap-around with no flags; result[63:32]=0.
- Z, HI, LO update:
  - Zin_low=1 -> Zlow<=result[31:0] and LO<=result[31:0].
  - Zin_high=1 -> Zhigh<=result[63:32] and HI<=result[63:32].
  - HI/LO hold otherwise.
- Latency: one cycle per transfer. The ALU result sampled at an edge reflects Y, bus and operation settled before that edge.
- Simultaneous load and drive of the same register in one cycle: the register captures the bus value and the old value drives the bus (no combinational loop).
- clear mid-sequence aborts everything. Clock edges after clear deasserts resume with all registers zero.

Test Plan:
- Register load and add:
  - Stimulus: Mdatain=0x12, Read+MDRin one edge, then MDRout+R2in one edge -> R2=0x12. Likewise R3=0x14 and R1=0x18.
  - Then R2out+Yin; then R3out+operation=1+Zin_low; then Zlowout+R1in.
  - Required: R1=0x26.
- Fetch: with PC=0, PCout+MARin+IncPC+Zin_low, then Zlowout+PCin -> MAR=0, PC=1. Then Mdatain=0x06918000, Read+MDRin, then MDRout+IRin -> IR=0x06918000.
- ALU ops, with Y=0x12 and bus=0x14:
  - sub -> Zlow=0xFFFFFFFE
  - and -> 0x10
  - shl by 0x14 -> 0x01200000
  - rol of 0x80000001 by 1 -> 0x00000003
- Multiply/divide:
  - Y=0xFFFFFFFF, B=2, op 9, Zin_high+Zin_low -> Zhigh=HI=0xFFFFFFFF, Zlow=LO=0xFFFFFFFE.
  - Y=7, B=2, op 10 -> LO=3, HI=1.
  - B=0, op 10 -> LO=0, HI=7.
- Bus idle and priority: no out strobe + Yin -> Y=0. R1out and R2out both high + Yin -> Y=R1.
- Async clear: assert clear between edges with R1=0x26 -> R1, PC, Z read 0 before the next edge; loads resume normally after release.

Source files
------------

// File: rtl/data_path_if.sv
// Control strobe bundle for the single-bus datapath, plus the datapath's
// memory-facing and control-facing observation taps.
interface data_path_if #(
  parameter int WIDTH = 32
);
  // Bus drive selects.
  logic             PCout;
  logic             Zlowout;
  logic             Zhighout;
  logic             HIout;
  logic             LOout;
  logic             MDRout;
  logic             In_Portout;
  logic             Cout;
  logic [15:0]      Rout;       // bit i is Ri out
  // Load enables.
  logic             MARin;
  logic             PCin;
  logic             MDRin;
  logic             IRin;
  logic             Yin;
  logic [15:0]      Rin;        // bit i is Ri in
  logic             Zin_high;
  logic             Zin_low;
  // ALU and memory controls.
  logic             IncPC;
  logic             Read;
  logic             ADD;
  logic [3:0]       operation;
  logic [WIDTH-1:0] Mdatain;
  // Datapath taps toward memory and the control unit.
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] mar_out;
  logic [WIDTH-1:0] mdr_out;
  logic [WIDTH-1:0] ir_out;

  modport master (
    output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout,
    output MARin, PCin, MDRin, IRin, Yin, Rin, Zin_high, Zin_low,
    output IncPC, Read, ADD, operation, Mdatain,
    input  bus_out, mar_out, mdr_out, ir_out
  );

  modport slave (
    input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout,
    input  MARin, PCin, MDRin, IRin, Yin, Rin, Zin_high, Zin_low,
    input  IncPC, Read, ADD, operation, Mdatain,
    output bus_out, mar_out, mdr_out, ir_out
  );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus CPU datapath: register file, PC/IR/MAR/MDR, Y/Z/HI/LO and
// a 64-bit ALU, all transfers steered by one-hot strobes on the interface.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic        Clock,
  input  logic        clear,
  data_path_if.slave  bus_if
);

  typedef enum logic [3:0] {
    OP_ZERO = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_SHR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIV  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12
  } alu_op_e;

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   r_d [16];
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   zhi_q, zhi_d;
  logic [WIDTH-1:0]   zlo_q, zlo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_result;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [4:0]         shamt;
  logic [5:0]         shamt_inv;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;
  alu_op_e            op;

  // Bus multiplexer: fixed priority, lowest-numbered register wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus = '0;
    if (|bus_if.Rout) begin
      for (int i = 15; i >= 0; i--) begin
        if (bus_if.Rout[i]) bus = r_q[i];
      end
    end else if (bus_if.HIout) begin
      bus = hi_q;
    end else if (bus_if.LOout) begin
      bus = lo_q;
    end else if (bus_if.Zhighout) begin
      bus = zhi_q;
    end else if (bus_if.Zlowout) begin
      bus = zlo_q;
    end else if (bus_if.PCout) begin
      bus = pc_q;
    end else if (bus_if.MDRout) begin
      bus = mdr_q;
    end else if (bus_if.In_Portout) begin
      bus = '0;
    end else if (bus_if.Cout) begin
      bus = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
    end
  end

  // ALU operands and the wide/slow results, computed unconditionally.
  always_comb begin
    alu_a     = y_q;
    alu_b     = bus;
    shamt     = alu_b[4:0];
    shamt_inv = 6'(WIDTH) - {1'b0, shamt};
    product   = $signed({{WIDTH{alu_a[WIDTH-1]}}, alu_a}) *
                $signed({{WIDTH{alu_b[WIDTH-1]}}, alu_b});
    if (alu_b == '0) begin
      quotient  = '0;
      remainder = alu_a;
    end else begin
      quotient  = $signed(alu_a) / $signed(alu_b);
      remainder = $signed(alu_a) % $signed(alu_b);
    end
  end

  // IncPC outranks ADD, which outranks the opcode.
  always_comb begin
    op         = alu_op_e'(bus_if.operation);
    alu_result = '0;
    if (bus_if.IncPC) begin
      alu_result[WIDTH-1:0] = alu_b + WIDTH'(1);
    end else if (bus_if.ADD) begin
      alu_result[WIDTH-1:0] = alu_a + alu_b;
    end else begin
      case (op)
        OP_ADD:  alu_result[WIDTH-1:0] = alu_a + alu_b;
        OP_SUB:  alu_result[WIDTH-1:0] = alu_a - alu_b;
        OP_AND:  alu_result[WIDTH-1:0] = alu_a & alu_b;
        OP_OR:   alu_result[WIDTH-1:0] = alu_a | alu_b;
        OP_SHR:  alu_result[WIDTH-1:0] = alu_a >> shamt;
        OP_SHL:  alu_result[WIDTH-1:0] = alu_a << shamt;
        OP_ROR:  alu_result[WIDTH-1:0] = (alu_a >> shamt) | (alu_a << shamt_inv);
        OP_ROL:  alu_result[WIDTH-1:0] = (alu_a << shamt) | (alu_a >> shamt_inv);
        OP_MUL:  alu_result            = product;
        OP_DIV:  alu_result            = {remainder, quotient};
        OP_NEG:  alu_result[WIDTH-1:0] = WIDTH'(0) - alu_b;
        OP_NOT:  alu_result[WIDTH-1:0] = ~alu_b;
        default: alu_result            = '0;
      endcase
    end
  end

  // Next-state for every register; a register loading from the bus while
  // driving it sees its old value, so there is no combinational loop.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = bus_if.Rin[i] ? bus : r_q[i];
    end
    pc_d  = bus_if.PCin  ? bus : pc_q;
    ir_d  = bus_if.IRin  ? bus : ir_q;
    y_d   = bus_if.Yin   ? bus : y_q;
    mar_d = bus_if.MARin ? bus : mar_q;
    mdr_d = mdr_q;
    if (bus_if.MDRin) mdr_d = bus_if.Read ? bus_if.Mdatain : bus;
    zlo_d = bus_if.Zin_low  ? alu_result[WIDTH-1:0]       : zlo_q;
    lo_d  = bus_if.Zin_low  ? alu_result[WIDTH-1:0]       : lo_q;
    zhi_d = bus_if.Zin_high ? alu_result[2*WIDTH-1:WIDTH] : zhi_q;
    hi_d  = bus_if.Zin_high ? alu_result[2*WIDTH-1:WIDTH] : hi_q;
  end

  // NOTE: the register file is small and architecturally visible, so it is
  // cleared with everything else rather than left as an unreset memory.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  assign bus_if.bus_out = bus;
  assign bus_if.mar_out = mar_q;
  assign bus_if.mdr_out = mdr_q;
  assign bus_if.ir_out  = ir_q;

endmodule

// File: tb/tb_data_path.sv
// Table-driven bench for data_path: each row is one clock of strobes plus an
// expected register value, queued when driven and compared after the edge.
module tb_data_path;

  localparam logic [17:0] PCO  = 18'h00001;
  localparam logic [17:0] ZLO  = 18'h00002;
  localparam logic [17:0] ZHO  = 18'h00004;
  localparam logic [17:0] HIO  = 18'h00008;
  localparam logic [17:0] LOO  = 18'h00010;
  localparam logic [17:0] MDRO = 18'h00020;
  localparam logic [17:0] INO  = 18'h00040;
  localparam logic [17:0] CO   = 18'h00080;
  localparam logic [17:0] MARI = 18'h00100;
  localparam logic [17:0] PCI  = 18'h00200;
  localparam logic [17:0] MDRI = 18'h00400;
  localparam logic [17:0] IRI  = 18'h00800;
  localparam logic [17:0] YI   = 18'h01000;
  localparam logic [17:0] INC  = 18'h02000;
  localparam logic [17:0] RD   = 18'h04000;
  localparam logic [17:0] ADDS = 18'h08000;
  localparam logic [17:0] ZHI  = 18'h10000;
  localparam logic [17:0] ZLI  = 18'h20000;

  typedef enum {OBS_NONE, OBS_R, OBS_PC, OBS_IR, OBS_Y, OBS_ZH, OBS_ZL,
                OBS_HI, OBS_LO, OBS_MAR, OBS_MDR} obs_t;

  typedef struct {
    string       name;
    logic [17:0] s;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [31:0] md;
    logic [3:0]  op;
    obs_t        obs;
    logic [3:0]  idx;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    obs_t        obs;
    logic [3:0]  idx;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  sb_t  exp_q[$];

  data_path_if #(.WIDTH(32)) dp_if ();

  data_path #(.WIDTH(32)) dut (
    .Clock  (clk),
    .clear  (clear),
    .bus_if (dp_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input obs_t o, input logic [3:0] idx);
    case (o)
      OBS_R:   return dut.r_q[idx];
      OBS_PC:  return dut.pc_q;
      OBS_IR:  return dp_if.ir_out;
      OBS_Y:   return dut.y_q;
      OBS_ZH:  return dut.zhi_q;
      OBS_ZL:  return dut.zlo_q;
      OBS_HI:  return dut.hi_q;
      OBS_LO:  return dut.lo_q;
      OBS_MAR: return dp_if.mar_out;
      OBS_MDR: return dp_if.mdr_out;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void row(input string name, input logic [17:0] s,
                              input logic [15:0] ro, input logic [15:0] ri,
                              input logic [31:0] md, input logic [3:0] op,
                              input obs_t obs, input logic [3:0] idx,
                              input logic [31:0] exp);
    vecs.push_back('{name, s, ro, ri, md, op, obs, idx, exp});
  endfunction

  task automatic apply(input vec_t v);
    dp_if.PCout      = v.s[0];
    dp_if.Zlowout    = v.s[1];
    dp_if.Zhighout   = v.s[2];
    dp_if.HIout      = v.s[3];
    dp_if.LOout      = v.s[4];
    dp_if.MDRout     = v.s[5];
    dp_if.In_Portout = v.s[6];
    dp_if.Cout       = v.s[7];
    dp_if.MARin      = v.s[8];
    dp_if.PCin       = v.s[9];
    dp_if.MDRin      = v.s[10];
    dp_if.IRin       = v.s[11];
    dp_if.Yin        = v.s[12];
    dp_if.IncPC      = v.s[13];
    dp_if.Read       = v.s[14];
    dp_if.ADD        = v.s[15];
    dp_if.Zin_high   = v.s[16];
    dp_if.Zin_low    = v.s[17];
    dp_if.Rout       = v.ro;
    dp_if.Rin        = v.ri;
    dp_if.Mdatain    = v.md;
    dp_if.operation  = v.op;
  endtask

  task automatic step(input vec_t v);
    sb_t e;
    @(negedge clk);
    apply(v);
    if (v.obs != OBS_NONE) exp_q.push_back('{v.name, v.obs, v.idx, v.exp});
    @(posedge clk);
    #1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, observe(e.obs, e.idx), e.exp);
    end
  endtask

  vec_t idle_v;

  initial begin
    idle_v = '{"idle", 18'h0, 16'h0, 16'h0, 32'h0, 4'h0, OBS_NONE, 4'h0, 32'h0};

    // Load/add sequence.
    row("mdr_0x12",   RD|MDRI,     16'h0,    16'h0,    32'h12, 4'd0, OBS_MDR, 0, 32'h12);
    row("r2_load",    MDRO,        16'h0,    16'h0004, 32'h0,  4'd0, OBS_R,   2, 32'h12);
    row("mdr_0x14",   RD|MDRI,     16'h0,    16'h0,    32'h14, 4'd0, OBS_MDR, 0, 32'h14);
    row("r3_load",    MDRO,        16'h0,    16'h0008, 32'h0,  4'd0, OBS_R,   3, 32'h14);
    row("mdr_0x18",   RD|MDRI,     16'h0,    16'h0,    32'h18, 4'd0, OBS_MDR, 0, 32'h18);
    row("r1_load",    MDRO,        16'h0,    16'h0002, 32'h0,  4'd0, OBS_R,   1, 32'h18);
    row("y_from_r2",  YI,          16'h0004, 16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h12);
    row("add_zlow",   ZLI,         16'h0008, 16'h0,    32'h0,  4'd1, OBS_ZL,  0, 32'h26);
    row("add_lo",     18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_LO,  0, 32'h26);
    row("r1_sum",     ZLO,         16'h0,    16'h0002, 32'h0,  4'd0, OBS_R,   1, 32'h26);
    // Fetch.
    row("fetch_mar",  PCO|MARI|INC|ZLI, 16'h0, 16'h0,  32'h0,  4'd0, OBS_MAR, 0, 32'h0);
    row("fetch_pc",   ZLO|PCI,     16'h0,    16'h0,    32'h0,  4'd0, OBS_PC,  0, 32'h1);
    row("fetch_mdr",  RD|MDRI,     16'h0,    16'h0,    32'h06918000, 4'd0, OBS_MDR, 0, 32'h06918000);
    row("fetch_ir",   MDRO|IRI,    16'h0,    16'h0,    32'h0,  4'd0, OBS_IR,  0, 32'h06918000);
    // ALU ops, Y=0x12, bus=R3=0x14.
    row("op_sub",     ZLI,         16'h0008, 16'h0,    32'h0,  4'd2, OBS_ZL,  0, 32'hFFFFFFFE);
    row("op_and",     ZLI,         16'h0008, 16'h0,    32'h0,  4'd3, OBS_ZL,  0, 32'h10);
    row("op_or",      ZLI,         16'h0008, 16'h0,    32'h0,  4'd4, OBS_ZL,  0, 32'h16);
    row("op_shl",     ZLI,         16'h0008, 16'h0,    32'h0,  4'd6, OBS_ZL,  0, 32'h01200000);
    row("add_strobe", ZLI|ADDS,    16'h0008, 16'h0,    32'h0,  4'd2, OBS_ZL,  0, 32'h26);
    row("incpc_prio", ZLI|ADDS|INC,16'h0008, 16'h0,    32'h0,  4'd2, OBS_ZL,  0, 32'h15);
    // Rotates and shift right, Y=0x80000001, bus=PC=1.
    row("mdr_rot",    RD|MDRI,     16'h0,    16'h0,    32'h80000001, 4'd0, OBS_MDR, 0, 32'h80000001);
    row("y_rot",      MDRO|YI,     16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h80000001);
    row("op_rol",     PCO|ZLI,     16'h0,    16'h0,    32'h0,  4'd8, OBS_ZL,  0, 32'h00000003);
    row("op_ror",     PCO|ZLI,     16'h0,    16'h0,    32'h0,  4'd7, OBS_ZL,  0, 32'hC0000000);
    row("op_shr",     PCO|ZLI,     16'h0,    16'h0,    32'h0,  4'd5, OBS_ZL,  0, 32'h40000000);
    // Signed multiply.
    row("mdr_m1",     RD|MDRI,     16'h0,    16'h0,    32'hFFFFFFFF, 4'd0, OBS_NONE, 0, 32'h0);
    row("y_m1",       MDRO|YI,     16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'hFFFFFFFF);
    row("mdr_2a",     RD|MDRI,     16'h0,    16'h0,    32'h2,  4'd0, OBS_NONE, 0, 32'h0);
    row("mul_zhigh",  MDRO|ZHI|ZLI,16'h0,    16'h0,    32'h0,  4'd9, OBS_ZH,  0, 32'hFFFFFFFF);
    row("mul_zlow",   18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_ZL,  0, 32'hFFFFFFFE);
    row("mul_hi",     18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_HI,  0, 32'hFFFFFFFF);
    row("mul_lo",     18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_LO,  0, 32'hFFFFFFFE);
    // Signed divide, including divide by zero and a negative dividend.
    row("mdr_7",      RD|MDRI,     16'h0,    16'h0,    32'h7,  4'd0, OBS_NONE, 0, 32'h0);
    row("y_7",        MDRO|YI,     16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h7);
    row("mdr_2b",     RD|MDRI,     16'h0,    16'h0,    32'h2,  4'd0, OBS_NONE, 0, 32'h0);
    row("div_lo",     MDRO|ZHI|ZLI,16'h0,    16'h0,    32'h0,  4'd10, OBS_LO, 0, 32'h3);
    row("div_hi",     18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_HI,  0, 32'h1);
    row("div0_hi",    ZHI|ZLI,     16'h0,    16'h0,    32'h0,  4'd10, OBS_HI, 0, 32'h7);
    row("div0_lo",    18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_LO,  0, 32'h0);
    row("mdr_m7",     RD|MDRI,     16'h0,    16'h0,    32'hFFFFFFF9, 4'd0, OBS_NONE, 0, 32'h0);
    row("y_m7",       MDRO|YI,     16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'hFFFFFFF9);
    row("mdr_2c",     RD|MDRI,     16'h0,    16'h0,    32'h2,  4'd0, OBS_NONE, 0, 32'h0);
    row("divn_lo",    MDRO|ZHI|ZLI,16'h0,    16'h0,    32'h0,  4'd10, OBS_LO, 0, 32'hFFFFFFFD);
    row("divn_hi",    18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_HI,  0, 32'hFFFFFFFF);
    row("add_zhigh0", PCO|ZHI|ZLI, 16'h0,    16'h0,    32'h0,  4'd1, OBS_ZH,  0, 32'h0);
    row("add_zlow_w", 18'h0,       16'h0,    16'h0,    32'h0,  4'd0, OBS_ZL,  0, 32'hFFFFFFFA);
    // Bus idle, priority and the C / In_Port sources.
    row("bus_idle",   YI,          16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h0);
    row("prio_r1_r2", YI,          16'h0006, 16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h26);
    row("prio_lo_pc", LOO|PCO|MDRO|YI, 16'h0, 16'h0,   32'h0,  4'd0, OBS_Y,   0, 32'hFFFFFFFA);
    row("prio_pc_mdr",PCO|MDRO|YI, 16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h1);
    row("mdr_imm",    RD|MDRI,     16'h0,    16'h0,    32'h00040005, 4'd0, OBS_NONE, 0, 32'h0);
    row("ir_imm",     MDRO|IRI,    16'h0,    16'h0,    32'h0,  4'd0, OBS_IR,  0, 32'h00040005);
    row("c_sext",     CO|YI,       16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'hFFFC0005);
    row("inport_prio",INO|CO|YI,   16'h0,    16'h0,    32'h0,  4'd0, OBS_Y,   0, 32'h0);
    row("self_xfer",  18'h0,       16'h0002, 16'h0002, 32'h0,  4'd0, OBS_R,   1, 32'h26);
    // Unary and undefined opcodes, Y=0, bus=R1=0x26.
    row("op_not",     ZLI,         16'h0002, 16'h0,    32'h0,  4'd12, OBS_ZL, 0, 32'hFFFFFFD9);
    row("op_zero",    ZLI,         16'h0002, 16'h0,    32'h0,  4'd0, OBS_ZL,  0, 32'h0);
    row("op_13",      ZLI,         16'h0002, 16'h0,    32'h0,  4'd13, OBS_ZL, 0, 32'h0);
    row("op_neg",     ZLI,         16'h0002, 16'h0,    32'h0,  4'd11, OBS_ZL, 0, 32'hFFFFFFDA);

    // Reset state, observed while clear is held and no edge has loaded anything.
    apply(idle_v);
    #1 clear = 1'b1;
    #2;
    check("rst_r1",  observe(OBS_R, 1), 32'h0);
    check("rst_pc",  observe(OBS_PC, 0), 32'h0);
    check("rst_ir",  observe(OBS_IR, 0), 32'h0);
    check("rst_hi",  observe(OBS_HI, 0), 32'h0);
    @(negedge clk);
    clear = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous clear between edges, then normal operation resumes.
    @(negedge clk);
    apply(idle_v);
    #1 clear = 1'b1;
    #1;
    check("aclr_r1",   observe(OBS_R, 1), 32'h0);
    check("aclr_pc",   observe(OBS_PC, 0), 32'h0);
    check("aclr_zlow", observe(OBS_ZL, 0), 32'h0);
    check("aclr_mdr",  observe(OBS_MDR, 0), 32'h0);
    #1 clear = 1'b0;
    step('{"post_r1",   18'h0,   16'h0, 16'h0,    32'h0,  4'd0, OBS_R,   4'd1, 32'h0});
    step('{"post_mdr",  RD|MDRI, 16'h0, 16'h0,    32'h55, 4'd0, OBS_MDR, 4'd0, 32'h55});
    step('{"post_r4",   MDRO,    16'h0, 16'h0010, 32'h0,  4'd0, OBS_R,   4'd4, 32'h55});
    step('{"post_inc",  PCO|INC|ZLI, 16'h0, 16'h0, 32'h0, 4'd0, OBS_ZL,  4'd0, 32'h1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
